// File: rtl/snd_pkg.sv
// snd_pkg: shared types, constants and the saturation helper for the
// stereo PDM output stage.
//   SMP_W           sample width of the mixer output
//   FB_POS/FB_NEG   modulator feedback levels (full-scale +/-1.0)
//   I1W_DEF/I2W_DEF default integrator widths
//   smp_pair_t      one L/R sample pair (l in the low half)
//   sat_s()         clamp a signed value to a signed 'w'-bit range
package snd_pkg;

   localparam int SMP_W   = 16;
   localparam int NUM_CH  = 2;
   localparam int FB_POS  = 32768;
   localparam int FB_NEG  = -32768;
   localparam int I1W_DEF = 20;
   localparam int I2W_DEF = 24;

   typedef struct packed {
      logic [SMP_W-1:0] r;
      logic [SMP_W-1:0] l;
   } smp_pair_t;

   // Clamp v to [-2^(w-1), 2^(w-1)-1]; never wraps.
   function automatic logic signed [31:0] sat_s(input logic signed [31:0] v,
                                                input int                 w);
      logic signed [31:0] hi;
      logic signed [31:0] lo;
      hi = (32'sd1 <<< (w - 1)) - 32'sd1;
      lo = -(32'sd1 <<< (w - 1));
      if (v > hi)      return hi;
      else if (v < lo) return lo;
      else             return v;
   endfunction

endpackage

// File: rtl/snd_pdm_out_dsm2.sv
// snd_dsm2: one channel of the 2nd-order delta-sigma modulator.
//   clk, reset  system clock, synchronous active-high reset
//   x           signed input, already attenuated by 6 dB
//   y           registered 1-bit modulator output
// Both integrators saturate rather than wrap, so an overload degrades
// gracefully instead of producing a full-scale limit cycle.
module snd_dsm2
   import snd_pkg::*;
#(
   parameter int I1W = I1W_DEF,
   parameter int I2W = I2W_DEF
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic signed [SMP_W-1:0] x,
   output logic                    y
);

   logic signed [I1W-1:0] i1;
   logic signed [I2W-1:0] i2;
   logic signed [I1W-1:0] i1_nxt;
   logic signed [I2W-1:0] i2_nxt;
   logic signed [31:0]    fb;
   logic                  q;

   always_comb begin
      // quantiser: sign of the second integrator
      q      = ~i2[I2W-1];
      fb     = q ? 32'(FB_POS) : 32'(FB_NEG);
      i1_nxt = I1W'(sat_s(32'(i1) + 32'(x) - fb, I1W));
      i2_nxt = I2W'(sat_s(32'(i2) + 32'(i1_nxt) - fb, I2W));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         i1 <= '0;
         i2 <= '0;
         y  <= 1'b0;
      end else begin
         i1 <= i1_nxt;
         i2 <= i2_nxt;
         y  <= q;
      end
   end

endmodule

// File: rtl/snd_pdm_out.sv
// snd_pdm_out: stereo output stage, mixer -> two PDM pins.
//   clk, reset     24 MHz clock, synchronous active-high reset
//   in_valid/in_l/in_r/in_ready  signed L/R pair handshake
//   tick           one-cycle pulse at each sample boundary (every DIV clocks)
//   underrun       one-cycle pulse when a tick finds the buffer empty
//   underrun_cnt   saturating count of underruns
//   pdm            modulator bits, [0]=left, [1]=right
// A one-deep buffer decouples the producer from the sample clock; the
// active pair only changes on a tick and is held across underruns.
module snd_pdm_out
   import snd_pkg::*;
#(
   parameter int DIV = 500,
   parameter int I1W = I1W_DEF,
   parameter int I2W = I2W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [SMP_W-1:0]  in_l,
   input  logic [SMP_W-1:0]  in_r,
   output logic              in_ready,
   output logic              tick,
   output logic              underrun,
   output logic [7:0]        underrun_cnt,
   output logic [NUM_CH-1:0] pdm
);

   localparam int CW = $clog2(DIV);

   logic [CW-1:0] div_cnt;
   logic          buf_full;
   logic          accept;
   smp_pair_t     buf_q;
   smp_pair_t     act_q;
   logic [NUM_CH-1:0][SMP_W-1:0] act_v;

   assign in_ready = ~buf_full;
   assign accept   = in_valid & ~buf_full;
   assign tick     = (div_cnt == CW'(DIV - 1));
   assign underrun = tick & ~buf_full;
   assign act_v    = act_q;  // packs as {r, l}: lane 0 = left

   always_ff @(posedge clk) begin
      if (reset) begin
         div_cnt      <= '0;
         buf_full     <= 1'b0;
         buf_q        <= '0;
         act_q        <= '0;
         underrun_cnt <= '0;
      end else begin
         div_cnt <= tick ? '0 : div_cnt + CW'(1);
         if (tick && buf_full) begin
            act_q    <= buf_q;
            buf_full <= 1'b0;
         end
         if (underrun && underrun_cnt != 8'hFF)
            underrun_cnt <= underrun_cnt + 8'd1;
         // accept and (tick & buf_full) are mutually exclusive, so an
         // acceptance on an underrunning tick simply lands in the buffer
         if (accept) begin
            buf_q    <= '{r: in_r, l: in_l};
            buf_full <= 1'b1;
         end
      end
   end

   for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
      logic signed [SMP_W-1:0] x;
      // -6 dB headroom keeps the 2nd-order loop stable at full scale
      assign x = $signed(act_v[ch]) >>> 1;

      snd_dsm2 #(
         .I1W (I1W),
         .I2W (I2W)
      ) u_dsm (
         .clk   (clk),
         .reset (reset),
         .x     (x),
         .y     (pdm[ch])
      );
   end

endmodule

// File: tb/tb_snd_pdm_out.sv
`timescale 1ns/1ps
module tb_snd_pdm_out;

   localparam int DIV = 64;
   localparam int I1W = 20;
   localparam int I2W = 24;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic [15:0] in_l = '0;
   logic [15:0] in_r = '0;
   logic        in_ready, tick, underrun;
   logic [7:0]  underrun_cnt;
   logic [1:0]  pdm;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 0;

   always #5 clk = ~clk;

   snd_pdm_out #(.DIV(DIV), .I1W(I1W), .I2W(I2W)) dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_l         (in_l),
      .in_r         (in_r),
      .in_ready     (in_ready),
      .tick         (tick),
      .underrun     (underrun),
      .underrun_cnt (underrun_cnt),
      .pdm          (pdm)
   );

   // ---------------- behavioural model ----------------
   logic [31:0] m_q[$];          // buffered pairs {l,r}, never more than one
   logic [31:0] m_act = '0;
   logic [31:0] activated[$];
   logic [31:0] sent[$];
   longint      m_i1[2];
   longint      m_i2[2];
   int          m_cnt  = 0;
   int          m_ucnt = 0;
   logic [1:0]  m_pdm  = '0;
   bit          sat_hit = 0;
   int          tog0 = 0, tog1 = 0;
   logic [1:0]  pdm_prev = '0;

   function automatic longint sat(input longint v, input int w);
      longint lim;
      lim = longint'(1) << (w - 1);
      if (v > lim - 1) return lim - 1;
      if (v < -lim)    return -lim;
      return v;
   endfunction

   initial begin
      m_i1[0] = 0; m_i1[1] = 0; m_i2[0] = 0; m_i2[1] = 0;
   end

   always @(posedge clk) begin
      bit          tk, acc;
      longint      x, fb, r1, r2, l1, l2;
      logic [15:0] s;
      if (reset) begin
         m_q.delete();
         m_act = '0; m_cnt = 0; m_ucnt = 0; m_pdm = '0;
         for (int c = 0; c < 2; c++) begin m_i1[c] = 0; m_i2[c] = 0; end
      end else begin
         tk  = (m_cnt == DIV - 1);
         acc = in_valid && (m_q.size() == 0);
         l1  = longint'(1) << (I1W - 1);
         l2  = longint'(1) << (I2W - 1);
         for (int c = 0; c < 2; c++) begin
            s  = (c == 0) ? m_act[31:16] : m_act[15:0];
            x  = longint'($signed(s)) >>> 1;
            fb = (m_i2[c] >= 0) ? 32768 : -32768;
            m_pdm[c] = (m_i2[c] >= 0);
            r1 = m_i1[c] + x - fb;
            m_i1[c] = sat(r1, I1W);
            r2 = m_i2[c] + m_i1[c] - fb;
            m_i2[c] = sat(r2, I2W);
            if (r1 >= l1 - 1 || r1 <= -l1 || r2 >= l2 - 1 || r2 <= -l2) sat_hit = 1;
         end
         if (tk) begin
            if (m_q.size() != 0) begin
               m_act = m_q.pop_front();
               activated.push_back(m_act);
            end else if (m_ucnt < 255) m_ucnt++;
         end
         if (acc) m_q.push_back({in_l, in_r});
         m_cnt = (m_cnt + 1) % DIV;
      end
   end

   // per-cycle compare of every output against the model
   always @(negedge clk) begin
      logic exp_rdy, exp_tick, exp_und;
      if (chk_en) begin
         exp_rdy  = (m_q.size() == 0);
         exp_tick = (m_cnt == DIV - 1);
         exp_und  = exp_tick && exp_rdy;
         n_tests++;
         if ({in_ready, tick, underrun, underrun_cnt, pdm} !==
             {exp_rdy, exp_tick, exp_und, 8'(m_ucnt), m_pdm}) begin
            n_fail++;
            $display("FAIL outputs t=%0t: got rdy=%b tick=%b und=%b ucnt=%0d pdm=%b, expected rdy=%b tick=%b und=%b ucnt=%0d pdm=%b",
                     $time, in_ready, tick, underrun, underrun_cnt, pdm,
                     exp_rdy, exp_tick, exp_und, m_ucnt, m_pdm);
         end
         if (pdm[0] !== pdm_prev[0]) tog0++;
         if (pdm[1] !== pdm_prev[1]) tog1++;
         pdm_prev = pdm;
      end
   end

   // ---------------- helpers ----------------
   task automatic chk(input string nm, input longint got, input longint exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, got, exp);
      end
   endtask

   task automatic chk_near(input string nm, input longint got, input longint exp, input longint tol);
      n_tests++;
      if (got > exp + tol || got < exp - tol) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d +/- %0d", nm, got, exp, tol);
      end
   endtask

   // entered and left at posedge+2
   task automatic send(input logic [15:0] l, input logic [15:0] r);
      int  n;
      bit  rdy;
      n = 0;
      in_valid = 1; in_l = l; in_r = r;
      forever begin
         @(negedge clk); rdy = in_ready;
         @(posedge clk); #2;
         if (rdy) begin sent.push_back({l, r}); break; end
         n++;
         if (n > 4 * DIV) begin chk("send_timeout", 1, 0); break; end
      end
      in_valid = 0;
   endtask

   task automatic density(input logic [15:0] l, input logic [15:0] r,
                          input int exp_l, input int exp_r);
      int o0, o1;
      bit seen;
      o0 = 0; o1 = 0; seen = 0;
      fork
         begin
            for (int i = 0; i < 175; i++) send(l, r);
         end
         begin
            for (int k = 0; k < 20 * DIV && !seen; k++) begin
               @(negedge clk); seen = (m_act == {l, r});
            end
            chk("density_active", seen, 1);
            repeat (4) @(negedge clk);
            for (int k = 0; k < 10000; k++) begin
               @(negedge clk); o0 += int'(pdm[0]); o1 += int'(pdm[1]);
            end
            chk_near("density_left", o0, exp_l, 4);
            chk_near("density_right", o1, exp_r, 4);
         end
      join
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #1500000;
      n_fail++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // ---------------- main sequence ----------------
   initial begin
      int first_tick, reass, ticks, unds, nbad;

      // model pins
      chk("sat_hi", sat(600000, 20), 524287);
      chk("sat_lo", sat(-600000, 20), -524288);
      chk("sat_mid", sat(-1234, 24), -1234);

      // reset held 4 cycles with a pair already offered
      in_valid = 1; in_l = 16'd1234; in_r = 16'(-1234);
      @(posedge clk); #1 chk_en = 1;
      repeat (3) begin
         @(negedge clk);
         chk("reset_state", {in_ready, pdm, underrun_cnt}, {1'b1, 2'b00, 8'd0});
         @(posedge clk);
      end
      #2 reset = 0;

      // handshake and first-tick timing
      first_tick = 0; reass = 0;
      for (int n = 1; n <= 3 * DIV; n++) begin
         @(negedge clk);
         if (n == 1) chk("rdy_after_reset", in_ready, 1);
         if (n == 2) chk("rdy_drop", in_ready, 0);
         if (tick && first_tick == 0) first_tick = n;
         if (n > 2 && in_ready && reass == 0) reass = n;
         @(posedge clk); #2;
         if (n == 1) begin
            sent.push_back({16'd1234, 16'(-1234)});
            in_l = 16'd555; in_r = 16'(-555);
         end
         if (reass != 0) begin
            sent.push_back({16'd555, 16'(-555)});
            in_valid = 0;
            break;
         end
      end
      chk("first_tick_cycle", first_tick, DIV);
      chk("rdy_reassert_cycle", reass, DIV + 1);

      // 100 random pairs with random producer gaps
      for (int i = 0; i < 100; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, DIV)) @(posedge clk);
            #2;
         end
         send(16'($urandom), 16'($urandom));
      end
      repeat (2 * DIV + 2) @(posedge clk);
      #2;
      chk("scoreboard_len", activated.size(), sent.size());
      nbad = 0;
      for (int i = 0; i < sent.size() && i < activated.size(); i++)
         if (sent[i] != activated[i]) nbad++;
      chk("scoreboard_order", nbad, 0);

      // ones density
      density(16'h0000, 16'h7FFF, 5000, 7500);
      density(16'h8000, 16'h7FFF, 2500, 7500);

      // underrun: 3 pairs then starve for 300 ticks
      for (int i = 0; i < 3; i++) send(16'($urandom), 16'($urandom));
      ticks = 0;
      for (int k = 0; k < 2 * DIV && ticks == 0; k++) begin
         @(negedge clk); if (tick) ticks = 1;
      end
      chk("last_pair_tick", ticks, 1);
      ticks = 0; unds = 0;
      for (int k = 0; k < 301 * DIV && ticks < 300; k++) begin
         @(negedge clk);
         if (tick) ticks++;
         if (underrun) unds++;
      end
      chk("starve_ticks", ticks, 300);
      chk("starve_underruns", unds, 300);
      chk("underrun_cnt_sat", underrun_cnt, 255);
      @(posedge clk); #2;

      // mid-run reset with buffer full and integrators busy
      send(16'h7FFF, 16'h7FFF);
      send(16'h1111, 16'h1111);
      repeat (5) @(posedge clk);
      #2 reset = 1;
      @(posedge clk); #2 reset = 0;
      @(negedge clk);
      chk("post_reset_state", {in_ready, tick, underrun, pdm, underrun_cnt},
          {1'b1, 1'b0, 1'b0, 2'b00, 8'd0});

      // acceptance on a tick with an empty buffer is still an underrun
      for (int n = 2; n <= DIV; n++) begin
         @(negedge clk);
         if (n == DIV) begin
            chk("coinc_tick", tick, 1);
            chk("coinc_underrun", underrun, 1);
            in_valid = 1; in_l = 16'h2222; in_r = 16'h2222;
         end
      end
      @(posedge clk); #2 in_valid = 0;
      @(negedge clk);
      chk("coinc_ucnt", underrun_cnt, 1);
      chk("coinc_buffered", in_ready, 0);
      repeat (DIV - 1) @(negedge clk);
      chk("coinc_tick2", tick, 1);
      chk("coinc_no_underrun", underrun, 0);
      @(negedge clk);
      chk("coinc_ucnt2", underrun_cnt, 1);
      chk("coinc_rdy2", in_ready, 1);
      chk("coinc_active", m_act, 32'h2222_2222);
      @(posedge clk); #2;

      // stability: full-scale alternation every tick
      sat_hit = 0; tog0 = 0; tog1 = 0;
      for (int i = 0; i < 200; i++)
         if (i % 2 == 0) send(16'h7FFF, 16'h8000);
         else            send(16'h8000, 16'h7FFF);
      repeat (2 * DIV) @(posedge clk);
      chk("stab_no_saturation", sat_hit, 0);
      chk("stab_toggle_l", tog0 > 100, 1);
      chk("stab_toggle_r", tog1 > 100, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
